// File: rtl/sys_defs.sv
// Shared system definitions for the memory bus.
// Holds the bus command encoding, the address width and the default
// channel and tag counts used by the arbiter and its tag table.
package sys_defs;

    localparam int XLEN          = 32;
    localparam int N_CH_DEFAULT  = 3;
    localparam int N_TAG_DEFAULT = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // Next channel index after idx, wrapping back to 0 past the last channel.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Memory tag ownership table.
// One entry per memory tag, each holding a valid bit and the index of the
// channel whose load was accepted with that tag.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   ret_tag            : tag returned by memory this cycle (0 = none)
//   alloc_en           : a load is being accepted this cycle
//   alloc_tag          : tag memory assigned to the accepted load
//   alloc_owner        : channel that issued the accepted load
//   ret_hit            : returned tag has a valid owner
//   ret_owner          : owner of the returned tag
//   ret_orphan         : returned tag has no valid owner
//   alloc_conflict     : allocation lands on an entry that stays occupied
//   any_valid          : at least one tag is outstanding
module mem_tag_table #(
    parameter int N_CH  = 3,
    parameter int N_TAG = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [$clog2(N_TAG)-1:0]   ret_tag,
    input  logic                       alloc_en,
    input  logic [$clog2(N_TAG)-1:0]   alloc_tag,
    input  logic [$clog2(N_CH)-1:0]    alloc_owner,
    output logic                       ret_hit,
    output logic [$clog2(N_CH)-1:0]    ret_owner,
    output logic                       ret_orphan,
    output logic                       alloc_conflict,
    output logic                       any_valid
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_TAG-1:0] valid;
    logic [CH_W-1:0]  owner [N_TAG];
    logic             ret_present;

    assign ret_present = (ret_tag != '0);
    assign ret_hit     = ret_present && valid[ret_tag];
    assign ret_orphan  = ret_present && !valid[ret_tag];
    assign ret_owner   = owner[ret_tag];
    assign any_valid   = |valid;

    // An allocation onto a still-valid entry is only legitimate when that
    // same entry is being returned in this very cycle.
    assign alloc_conflict = alloc_en && valid[alloc_tag] &&
                            !(ret_hit && (ret_tag == alloc_tag));

    // The return clears its entry first; an allocation of the same tag in
    // the same cycle comes later and so wins, leaving the new owner valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            for (int t = 0; t < N_TAG; t++) begin
                owner[t] <= '0;
            end
        end else begin
            if (ret_hit) begin
                valid[ret_tag] <= 1'b0;
            end
            if (alloc_en) begin
                valid[alloc_tag] <= 1'b1;
                owner[alloc_tag] <= alloc_owner;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter.
// Chooses one of N_CH requesting channels to drive the memory bus each
// cycle (fixed priority or round-robin), keeps retrying a rejected channel,
// and routes returned memory tags back to the channel that owns them.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   req_command/addr/data : per-channel bus request
//   mem_command/addr/data : request of the granted channel, to memory
//   mem2proc_response/data/tag : memory response, data and returned tag
//   ch_grant            : one-hot grant
//   ch_response         : memory response, steered to the granted channel
//   ch_tag              : returned tag, steered to its owner
//   ch_data             : memory data broadcast to every channel
//   all_idle            : no load tag outstanding
//   tag_err             : sticky tag-ownership error
module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int N_CH     = N_CH_DEFAULT,
    parameter int ARB_MODE = 1,
    parameter int N_TAG    = N_TAG_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CH-1:0][1:0]      req_command,
    input  logic [N_CH-1:0][XLEN-1:0] req_addr,
    input  logic [N_CH-1:0][63:0]     req_data,
    output logic [1:0]                mem_command,
    output logic [XLEN-1:0]           mem_addr,
    output logic [63:0]               mem_data,
    input  logic [3:0]                mem2proc_response,
    input  logic [63:0]               mem2proc_data,
    input  logic [3:0]                mem2proc_tag,
    output logic [N_CH-1:0]           ch_grant,
    output logic [N_CH-1:0][3:0]      ch_response,
    output logic [N_CH-1:0][3:0]      ch_tag,
    output logic [63:0]               ch_data,
    output logic                      all_idle,
    output logic                      tag_err
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int TAG_W = $clog2(N_TAG);

    logic [N_CH-1:0] cand;
    logic            grant_found;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] rr_ptr;
    logic            retry_valid;
    logic [CH_W-1:0] retry_ch;
    logic            accept;
    logic            load_accept;
    logic            ret_hit;
    logic [CH_W-1:0] ret_owner;
    logic            ret_orphan;
    logic            alloc_conflict;
    logic            any_valid;

    always_comb begin
        cand = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand[i] = (req_command[i] != BUS_NONE);
        end
    end

    // Grant selection. A channel rejected last cycle that is still asking
    // keeps the bus regardless of mode. Round-robin is done as two upward
    // passes: first from rr_ptr to the top, then from 0, which together
    // cover the circular search without modulo arithmetic.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (!reset) begin
            if (retry_valid && cand[retry_ch]) begin
                grant_found = 1'b1;
                grant_idx   = retry_ch;
            end else if (ARB_MODE == 0) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (cand[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = CH_W'(i);
                    end
                end
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (!grant_found && cand[i] && (i >= int'(rr_ptr))) begin
                        grant_found = 1'b1;
                        grant_idx   = CH_W'(i);
                    end
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (!grant_found && cand[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = CH_W'(i);
                    end
                end
            end
        end
    end

    // Output muxes toward memory and back toward the channels. Tag routing
    // is suppressed while reset is asserted because the table is being
    // cleared in that cycle.
    always_comb begin
        mem_command = BUS_NONE;
        mem_addr    = '0;
        mem_data    = '0;
        ch_grant    = '0;
        ch_response = '0;
        ch_tag      = '0;
        if (grant_found) begin
            mem_command            = req_command[grant_idx];
            mem_addr               = req_addr[grant_idx];
            mem_data               = req_data[grant_idx];
            ch_grant[grant_idx]    = 1'b1;
            ch_response[grant_idx] = mem2proc_response;
        end
        if (ret_hit && !reset) begin
            ch_tag[ret_owner] = mem2proc_tag;
        end
    end

    assign accept      = grant_found && (mem2proc_response != 4'd0);
    assign load_accept = accept && (mem_command == BUS_LOAD);
    assign ch_data     = mem2proc_data;
    assign all_idle    = ~any_valid;

    // Arbitration state: the round-robin pointer only moves on acceptance,
    // and the retry record always reflects what happened to last cycle's
    // grant (cleared when there was none or it was accepted).
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr      <= '0;
            retry_valid <= 1'b0;
            retry_ch    <= '0;
            tag_err     <= 1'b0;
        end else begin
            retry_valid <= grant_found && !accept;
            retry_ch    <= grant_idx;
            if (accept && (ARB_MODE == 1)) begin
                rr_ptr <= CH_W'(wrap_inc(int'(grant_idx), N_CH));
            end
            if (ret_orphan || alloc_conflict) begin
                tag_err <= 1'b1;
            end
        end
    end

    mem_tag_table #(
        .N_CH  (N_CH),
        .N_TAG (N_TAG)
    ) u_tag_table (
        .clock          (clock),
        .reset          (reset),
        .ret_tag        (mem2proc_tag[TAG_W-1:0]),
        .alloc_en       (load_accept),
        .alloc_tag      (mem2proc_response[TAG_W-1:0]),
        .alloc_owner    (grant_idx),
        .ret_hit        (ret_hit),
        .ret_owner      (ret_owner),
        .ret_orphan     (ret_orphan),
        .alloc_conflict (alloc_conflict),
        .any_valid      (any_valid)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a round-robin instance checked
// against a behavioural model and a vector table, plus a fixed-priority
// instance for the priority ordering.
module tb_mem_bus_arbiter;
    import sys_defs::*;

    localparam logic [1:0] CN = BUS_NONE;
    localparam logic [1:0] CL = BUS_LOAD;
    localparam logic [1:0] CS = BUS_STORE;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [2:0][1:0]      req_command = '0;
    logic [2:0][XLEN-1:0] req_addr = '0;
    logic [2:0][63:0]     req_data = '0;
    logic [1:0]           mem_command;
    logic [XLEN-1:0]      mem_addr;
    logic [63:0]          mem_data;
    logic [3:0]           mem2proc_response = '0;
    logic [63:0]          mem2proc_data = '0;
    logic [3:0]           mem2proc_tag = '0;
    logic [2:0]           ch_grant;
    logic [2:0][3:0]      ch_response;
    logic [2:0][3:0]      ch_tag;
    logic [63:0]          ch_data;
    logic                 all_idle;
    logic                 tag_err;

    logic [2:0][1:0]      fx_req_command = '0;
    logic [2:0][XLEN-1:0] fx_req_addr = {32'hC2, 32'hC1, 32'hC0};
    logic [2:0][63:0]     fx_req_data = '0;
    logic [1:0]           fx_mem_command;
    logic [XLEN-1:0]      fx_mem_addr;
    logic [63:0]          fx_mem_data;
    logic [3:0]           fx_response = '0;
    logic [2:0]           fx_ch_grant;
    logic [2:0][3:0]      fx_ch_response;
    logic [2:0][3:0]      fx_ch_tag;
    logic [63:0]          fx_ch_data;
    logic                 fx_all_idle;
    logic                 fx_tag_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: owner per tag (-1 = free), retry channel
    // (-1 = none), round-robin start point and sticky error.
    int m_owner [16];
    int m_retry = -1;
    int m_rr    = 0;
    bit m_err   = 1'b0;
    int cur_g   = -1;

    typedef struct {
        logic [2:0][1:0] cmd;
        logic [3:0]      resp;
        logic [3:0]      tag;
        logic [2:0]      exp_grant;
        logic [11:0]     exp_tag;
        logic            exp_idle;
        logic            exp_err;
    } vec_t;

    vec_t vecs [15];

    always #5 clock = ~clock;

    mem_bus_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .req_command       (req_command),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .mem_command       (mem_command),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .ch_grant          (ch_grant),
        .ch_response       (ch_response),
        .ch_tag            (ch_tag),
        .ch_data           (ch_data),
        .all_idle          (all_idle),
        .tag_err           (tag_err)
    );

    mem_bus_arbiter #(.ARB_MODE(0)) dut_fixed (
        .clock             (clock),
        .reset             (reset),
        .req_command       (fx_req_command),
        .req_addr          (fx_req_addr),
        .req_data          (fx_req_data),
        .mem_command       (fx_mem_command),
        .mem_addr          (fx_mem_addr),
        .mem_data          (fx_mem_data),
        .mem2proc_response (fx_response),
        .mem2proc_data     (64'd0),
        .mem2proc_tag      (4'd0),
        .ch_grant          (fx_ch_grant),
        .ch_response       (fx_ch_response),
        .ch_tag            (fx_ch_tag),
        .ch_data           (fx_ch_data),
        .all_idle          (fx_all_idle),
        .tag_err           (fx_tag_err)
    );

    task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (reset) return -1;
        if (m_retry >= 0 && req_command[2'(m_retry)] != CN) return m_retry;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_rr + k) % 3;
            if (req_command[2'(c)] != CN) return c;
        end
        return -1;
    endfunction

    function automatic bit model_idle();
        for (int t = 0; t < 16; t++) begin
            if (m_owner[t] >= 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Apply the effect of one rising edge to the model, using the inputs
    // that were present across that edge.
    task automatic model_update(input int g);
        if (reset) begin
            m_rr    = 0;
            m_retry = -1;
            m_err   = 1'b0;
            for (int t = 0; t < 16; t++) m_owner[t] = -1;
        end else begin
            if (mem2proc_tag != 4'd0) begin
                if (m_owner[mem2proc_tag] >= 0) m_owner[mem2proc_tag] = -1;
                else m_err = 1'b1;
            end
            if (g >= 0 && mem2proc_response != 4'd0) begin
                m_rr    = (g + 1) % 3;
                m_retry = -1;
                if (req_command[2'(g)] == CL) begin
                    if (m_owner[mem2proc_response] >= 0) m_err = 1'b1;
                    m_owner[mem2proc_response] = g;
                end
            end else begin
                m_retry = g;
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0][1:0] cmd, input logic [3:0] resp, input logic [3:0] tag);
        req_command       = cmd;
        mem2proc_response = resp;
        mem2proc_tag      = tag;
        mem2proc_data     = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            req_addr[2'(i)] = $urandom;
            req_data[2'(i)] = {$urandom, $urandom};
        end
    endtask

    // Compare every output of the round-robin instance against the model.
    task automatic checkOutput();
        logic [2:0]      eg;
        logic [1:0]      ecmd;
        logic [XLEN-1:0] eaddr;
        logic [63:0]     edata;
        logic [2:0][3:0] eresp;
        logic [2:0][3:0] etag;
        cur_g = model_grant();
        eg = '0; ecmd = CN; eaddr = '0; edata = '0; eresp = '0; etag = '0;
        if (cur_g >= 0) begin
            eg[2'(cur_g)]    = 1'b1;
            ecmd             = req_command[2'(cur_g)];
            eaddr            = req_addr[2'(cur_g)];
            edata            = req_data[2'(cur_g)];
            eresp[2'(cur_g)] = mem2proc_response;
        end
        if (!reset && mem2proc_tag != 4'd0 && m_owner[mem2proc_tag] >= 0)
            etag[2'(m_owner[mem2proc_tag])] = mem2proc_tag;
        check_value("m.grant", 64'(ch_grant), 64'(eg));
        check_value("m.mem_cmd", 64'(mem_command), 64'(ecmd));
        check_value("m.mem_addr", 64'(mem_addr), 64'(eaddr));
        check_value("m.mem_data", mem_data, edata);
        check_value("m.ch_resp", 64'(ch_response), 64'(eresp));
        check_value("m.ch_tag", 64'(ch_tag), 64'(etag));
        check_value("m.ch_data", ch_data, mem2proc_data);
        check_value("m.idle", 64'(all_idle), 64'(model_idle()));
        check_value("m.err", 64'(tag_err), 64'(m_err));
    endtask

    task automatic advance_clock();
        @(posedge clock);
        model_update(cur_g);
        #1;
    endtask

    task automatic hand_cycle(input string name, input logic [2:0][1:0] cmd, input logic [3:0] resp,
                              input logic [3:0] tag, input logic [2:0] exp_grant, input logic [11:0] exp_tag,
                              input logic exp_idle, input logic exp_err);
        applyStimulus(cmd, resp, tag);
        @(negedge clock);
        checkOutput();
        check_value({name, ".grant"}, 64'(ch_grant), 64'(exp_grant));
        check_value({name, ".tag"}, 64'(ch_tag), 64'(exp_tag));
        check_value({name, ".idle"}, 64'(all_idle), 64'(exp_idle));
        check_value({name, ".err"}, 64'(tag_err), 64'(exp_err));
        advance_clock();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus({CL, CS, CL}, 4'd3, 4'd0);
        @(negedge clock);
        checkOutput();
        check_value("rst.grant", 64'(ch_grant), 64'd0);
        advance_clock();
        reset = 1'b0;
    endtask

    initial begin
        for (int t = 0; t < 16; t++) m_owner[t] = -1;

        // Table: rotation with tag returns, same-cycle return/re-accept,
        // and a store whose tag comes back unowned.
        vecs[0]  = '{{CL, CL, CL}, 4'd1, 4'd0, 3'b001, 12'h000, 1'b1, 1'b0};
        vecs[1]  = '{{CL, CL, CL}, 4'd2, 4'd0, 3'b010, 12'h000, 1'b0, 1'b0};
        vecs[2]  = '{{CL, CL, CL}, 4'd3, 4'd1, 3'b100, 12'h001, 1'b0, 1'b0};
        vecs[3]  = '{{CL, CL, CL}, 4'd4, 4'd2, 3'b001, 12'h020, 1'b0, 1'b0};
        vecs[4]  = '{{CL, CL, CL}, 4'd5, 4'd3, 3'b010, 12'h300, 1'b0, 1'b0};
        vecs[5]  = '{{CN, CN, CN}, 4'd0, 4'd4, 3'b000, 12'h004, 1'b0, 1'b0};
        vecs[6]  = '{{CN, CN, CN}, 4'd0, 4'd5, 3'b000, 12'h050, 1'b0, 1'b0};
        vecs[7]  = '{{CN, CN, CN}, 4'd0, 4'd0, 3'b000, 12'h000, 1'b1, 1'b0};
        vecs[8]  = '{{CN, CN, CL}, 4'd4, 4'd0, 3'b001, 12'h000, 1'b1, 1'b0};
        vecs[9]  = '{{CL, CN, CN}, 4'd4, 4'd4, 3'b100, 12'h004, 1'b0, 1'b0};
        vecs[10] = '{{CN, CN, CN}, 4'd0, 4'd4, 3'b000, 12'h400, 1'b0, 1'b0};
        vecs[11] = '{{CN, CN, CN}, 4'd0, 4'd0, 3'b000, 12'h000, 1'b1, 1'b0};
        vecs[12] = '{{CN, CS, CN}, 4'd7, 4'd0, 3'b010, 12'h000, 1'b1, 1'b0};
        vecs[13] = '{{CN, CN, CN}, 4'd0, 4'd7, 3'b000, 12'h000, 1'b1, 1'b0};
        vecs[14] = '{{CN, CN, CN}, 4'd0, 4'd0, 3'b000, 12'h000, 1'b1, 1'b1};

        @(posedge clock);
        #1;
        // Requests present while reset is held must not be granted.
        hand_cycle("rst_req", {CL, CL, CL}, 4'd2, 4'd0, 3'b000, 12'h000, 1'b1, 1'b0);
        reset = 1'b0;

        for (int v = 0; v < 15; v++) begin
            hand_cycle($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].resp, vecs[v].tag,
                       vecs[v].exp_grant, vecs[v].exp_tag, vecs[v].exp_idle, vecs[v].exp_err);
        end

        // Sticky retry: channel 1 holds the bus through two rejections even
        // when channel 0 would win round-robin, then the pointer moves to 2.
        do_reset();
        hand_cycle("retry0", {CN, CL, CN}, 4'd0, 4'd0, 3'b010, 12'h000, 1'b1, 1'b0);
        hand_cycle("retry1", {CN, CL, CL}, 4'd0, 4'd0, 3'b010, 12'h000, 1'b1, 1'b0);
        hand_cycle("retry2", {CN, CL, CL}, 4'd5, 4'd0, 3'b010, 12'h000, 1'b1, 1'b0);
        hand_cycle("retry3", {CL, CL, CL}, 4'd0, 4'd0, 3'b100, 12'h000, 1'b0, 1'b0);
        hand_cycle("retry4", {CN, CN, CN}, 4'd0, 4'd5, 3'b000, 12'h050, 1'b0, 1'b0);
        hand_cycle("retry5", {CN, CN, CN}, 4'd0, 4'd0, 3'b000, 12'h000, 1'b1, 1'b0);

        // Reset with three tags outstanding, then a late return.
        do_reset();
        hand_cycle("rsttag0", {CL, CL, CL}, 4'd1, 4'd0, 3'b001, 12'h000, 1'b1, 1'b0);
        hand_cycle("rsttag1", {CL, CL, CL}, 4'd2, 4'd0, 3'b010, 12'h000, 1'b0, 1'b0);
        hand_cycle("rsttag2", {CL, CL, CL}, 4'd3, 4'd0, 3'b100, 12'h000, 1'b0, 1'b0);
        reset = 1'b1;
        hand_cycle("rsttag3", {CL, CL, CL}, 4'd6, 4'd0, 3'b000, 12'h000, 1'b0, 1'b0);
        reset = 1'b0;
        hand_cycle("rsttag4", {CN, CN, CN}, 4'd0, 4'd0, 3'b000, 12'h000, 1'b1, 1'b0);
        hand_cycle("rsttag5", {CN, CN, CN}, 4'd0, 4'd2, 3'b000, 12'h000, 1'b1, 1'b0);
        hand_cycle("rsttag6", {CN, CN, CN}, 4'd0, 4'd0, 3'b000, 12'h000, 1'b1, 1'b1);

        // Fixed priority instance: highest requesting index wins.
        do_reset();
        applyStimulus({CN, CN, CN}, 4'd0, 4'd0);
        for (int c = 0; c < 5; c++) begin
            logic [2:0]      eg;
            logic [XLEN-1:0] ea;
            if (c < 3) begin
                fx_req_command = {CL, CN, CL}; eg = 3'b100; ea = 32'hC2;
            end else if (c == 3) begin
                fx_req_command = {CN, CN, CL}; eg = 3'b001; ea = 32'hC0;
            end else begin
                fx_req_command = {CN, CL, CL}; eg = 3'b010; ea = 32'hC1;
            end
            fx_response = 4'd1;
            @(negedge clock);
            checkOutput();
            check_value($sformatf("fixed%0d.grant", c), 64'(fx_ch_grant), 64'(eg));
            check_value($sformatf("fixed%0d.addr", c), 64'(fx_mem_addr), 64'(ea));
            check_value($sformatf("fixed%0d.cmd", c), 64'(fx_mem_command), 64'(CL));
            advance_clock();
        end
        fx_req_command = '0;
        fx_response    = 4'd0;

        // Randomized traffic checked against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [2:0][1:0] cmd;
            logic [3:0]      resp;
            logic [3:0]      tag;
            int              owned [$];
            reset = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 3; i++) begin
                int r;
                r = $urandom_range(0, 3);
                cmd[2'(i)] = (r == 0) ? CN : ((r == 1) ? CS : CL);
            end
            resp = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            owned = {};
            for (int t = 1; t < 16; t++) if (m_owner[t] >= 0) owned.push_back(t);
            if ($urandom_range(0, 1) == 0) tag = 4'd0;
            else if (owned.size() > 0 && $urandom_range(0, 7) != 0)
                tag = 4'(owned[$urandom_range(0, owned.size() - 1)]);
            else tag = 4'($urandom_range(1, 15));
            applyStimulus(cmd, resp, tag);
            @(negedge clock);
            checkOutput();
            advance_clock();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter N_CH, default 3: number of requesting channels; legal range 2..8; index 0 is the icache.
REQ-002 Parameter ARB_MODE, default 1: 0 selects fixed priority (highest channel index wins), 1 selects round-robin.
REQ-003 Parameter N_TAG, default 16: size of the memory tag space; tag 0 means "no tag".
REQ-004 clock  input  1  system clock; the block has one clock, and all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_command  input  N_CH x 2  per-channel bus command: BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-007 req_addr  input  N_CH x XLEN  per-channel address.
REQ-008 req_data  input  N_CH x 64  per-channel store data.
REQ-009 mem_command / mem_addr / mem_data  output  2 / XLEN / 64  command, address and data driven to memory.
REQ-010 mem2proc_response / mem2proc_data / mem2proc_tag  input  4 / 64 / 4  memory response, returned data and returned tag.
REQ-011 ch_grant  output  N_CH  one-hot; marks the channel driving memory this cycle.
REQ-012 ch_response  output  N_CH x 4  equals mem2proc_response for the granted channel; 0 for every other channel.
REQ-013 ch_tag  output  N_CH x 4  equals mem2proc_tag for the channel that owns that tag; 0 for every other channel.
REQ-014 ch_data  output  64  mem2proc_data, broadcast to all channels.
REQ-015 all_idle  output  1  high when no load tag is outstanding.
REQ-016 tag_err  output  1  sticky; set when a returned tag has no owner.

Function
REQ-017 Grant shall be combinational from current req_command and registered state, with zero-cycle latency.
REQ-018 Candidate set: every channel whose req_command is not BUS_NONE.
REQ-019 With no candidates, ch_grant shall be 0 and mem_command shall be BUS_NONE.
REQ-020 Fixed mode: grant the highest-index candidate.
REQ-021 Round-robin mode: grant the first candidate at or after rr_ptr, searching upward modulo N_CH.
REQ-022 Sticky retry: if the previous grant received response 0 and that channel still requests, grant it again, overriding both modes.
REQ-023 Memory outputs shall mux the granted channel's command, address and data.
REQ-024 Acceptance means mem2proc_response != 0 while a grant is active.
REQ-025 On acceptance in round-robin mode, rr_ptr <= (granted + 1) mod N_CH.
REQ-026 On rejection (response 0 with a grant active), rr_ptr shall hold.
REQ-027 Load acceptance: owner[response] <= granted and valid[response] <= 1; store acceptance allocates no entry.
REQ-028 Tag return: if mem2proc_tag != 0 and valid[tag] is set, route the tag to owner[tag] via ch_tag and clear valid[tag].
REQ-029 Tag return with no valid entry: set tag_err and drive all ch_tag to 0.
REQ-030 Same tag returned and re-accepted in one cycle: the return routes to the old owner; the entry then ends valid with the new owner.
REQ-031 Re-acceptance of a tag that is still valid without a matching return: overwrite the entry and set tag_err.
REQ-032 all_idle = ~|valid, computed combinationally.

Reset
REQ-033 Reset shall set rr_ptr = 0, clear all valid bits, clear the sticky-retry state and clear tag_err.
REQ-034 During reset, ch_grant = 0 and mem_command = BUS_NONE regardless of requests.
REQ-035 Tags returning after reset shall be treated as unowned: tag_err is set.
REQ-036 Reset takes priority over any simultaneous acceptance or return.

Structure
REQ-037 BUS_COMMAND encoding, the default N_CH and N_TAG shall come from the shared sys_defs package.
REQ-038 The tag-ownership table shall be a sub-module, mem_tag_table (N_TAG entries of valid plus owner index).
REQ-039 The arbiter logic and the output muxes shall live in mem_bus_arbiter.

Verification
REQ-040 Round-robin, N_CH=3, all three channels issue LOAD every cycle, memory always responds 1..15 -> grants rotate 0,1,2,0 and each tag returns to its issuer.
REQ-041 Fixed mode, channels 0 and 2 both request -> channel 2 is granted every cycle and channel 0 is granted only after channel 2 drops.
REQ-042 Channel 1 is rejected twice (response 0), then accepted with tag 5 -> grant stays on channel 1 for all three cycles, and rr_ptr becomes 2 after the acceptance.
REQ-043 A STORE is accepted with tag 7, then tag 7 is returned -> no ch_tag is asserted and tag_err = 1.
REQ-044 Tag 4 is returned to channel 0 while channel 2's LOAD is accepted with tag 4 in the same cycle -> ch_tag[0] = 4; the next return of tag 4 routes to channel 2.
REQ-045 Reset is asserted with 3 tags outstanding -> all_idle = 1 in the next cycle, and a late return of one of those tags sets tag_err.
